sub_accum_sequencer: RTL and testbench
======================================

Name: sub_accum_sequencer

Overview:
Controller that sequences the 4-bit feedback subtractor. It accepts a job (initial value, operand, iteration count) over a valid/ready handshake and repeatedly subtracts the operand from an 8-bit accumulator, one subtraction per cycle. The run stops on count exhaustion or borrow, and the result is presented over a valid/ready handshake. It sits between the ALU command path and the subtract-with-feedback datapath.

Parameters:
DATA_W, 8, accumulator/result width
OPND_W, 4, operand width (zero-extended to DATA_W)
CNT_W, 4, iteration-count width (max run 2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start_valid  in  1  job request
start_ready  out  1  high only in IDLE
init_val  in  DATA_W  initial accumulator value
operand  in  OPND_W  subtrahend per iteration
iter_cnt  in  CNT_W  requested subtractions
res_valid  out  1  high only in DONE
res_ready  in  1  consumer accepts result
result  out  DATA_W  accumulator value
borrow_flag  out  1  run ended on borrow
iters_done  out  CNT_W  subtractions actually performed
busy  out  1  high in RUN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; every register clears on a clk edge while rst=1. rst has priority over all other inputs.
- Reset values: state IDLE, result 0, borrow_flag 0, iters_done 0, res_valid 0, busy 0, start_ready 1.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- IDLE, on accept (start_valid & start_ready):
  - capture acc<=init_val, op<=operand, remaining<=iter_cnt; clear iters_done and borrow_flag.
  - go to RUN if iter_cnt!=0, else DONE.
- Input capture: inputs are sampled only on accept; later changes have no effect.
- RUN, each edge:
  - if acc>=op: acc<=acc-op, iters_done+1, remaining-1; go to DONE when remaining==1.
  - if acc<op: acc<=(acc-op) mod 2^DATA_W, borrow_flag<=1, iters_done+1, go to DONE immediately.
- Operand 0: no borrow is possible; the run takes the full count and result=init_val.
- DONE:
  - res_valid=1; result, borrow_flag and iters_done held stable.
  - on res_ready=1, go to IDLE next edge.
  - res_ready may be held high permanently.
- Latency: for an accept in cycle k, res_valid is first high in cycle k+N+1, where N=iters_done (N=0 gives cycle k+1).
- Back-to-back jobs: start_valid is ignored in RUN and DONE (start_ready=0). Minimum spacing between accepts is N+2 cycles.
- result reflects acc in every state. It is only meaningful while res_valid=1.
- Reset mid-RUN or mid-DONE: the job is discarded, there is no partial result, and the FSM returns to IDLE with the reset values.
- Width rules: operand is zero-extended. Arithmetic is unsigned modulo 2^DATA_W. iters_done never exceeds iter_cnt.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, RUN, DONE}
  - DATA_W, OPND_W, CNT_W defaults
- One combinational sub-module, sub_step: inputs acc and op; outputs diff (DATA_W) and borrow. It encapsulates the subtract stage so the FSM stays pure control.

Test Plan:
- init 100, op 5, N=3, res_ready=1 -> result 85, borrow 0, iters 3, res_valid in cycle k+4, start_ready high cycle k+5.
- init 10, op 5, N=4 -> 10,5,0 then borrow: result 251, borrow 1, iters 3, res_valid in cycle k+4.
- init 42, op 7, N=0 -> res_valid in cycle k+1, result 42, iters 0, borrow 0.
- init 200, op 0, N=15 -> result 200, iters 15, borrow 0; start_valid pulsed during RUN is not accepted.
- Job (50,3,4) with res_ready low 5 cycles -> result 38 held stable and res_valid held high; start_valid during DONE ignored; IDLE one cycle after res_ready rises.
- rst=1 during 2nd RUN cycle -> next cycle busy 0, res_valid 0, result 0, start_ready 1; a following job (20,2,2) yields 16.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encoding and default widths for the subtract sequencer
package alu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPND_W = 4;
  localparam int DEF_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_step.sv
// sub_step: one unsigned modulo subtraction with borrow-out
module sub_step #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] op,
  output logic [DATA_W-1:0] diff,
  output logic              borrow
);
  assign diff = acc - op;
  assign borrow = acc < op;
endmodule

// File: rtl/sub_accum_sequencer.sv
// sub_accum_sequencer: runs repeated accumulator subtractions until count exhaustion or borrow
module sub_accum_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPND_W = DEF_OPND_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] init_val,
  input  logic [OPND_W-1:0] operand,
  input  logic [CNT_W-1:0]  iter_cnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              borrow_flag,
  output logic [CNT_W-1:0]  iters_done,
  output logic              busy
);
  state_t state, state_d;
  logic [DATA_W-1:0] acc, diff;
  logic [OPND_W-1:0] op;
  logic [CNT_W-1:0] remaining;
  logic step_borrow, accept;
  assign accept = start_valid && state == IDLE;
  sub_step #(.DATA_W(DATA_W)) u_step (
    .acc(acc),
    .op(DATA_W'(op)),
    .diff(diff),
    .borrow(step_borrow)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = accept ? (iter_cnt != '0 ? RUN : DONE) : IDLE;
      RUN: state_d = (step_borrow || remaining == CNT_W'(1)) ? DONE : RUN;
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      op <= '0;
      remaining <= '0;
      iters_done <= '0;
      borrow_flag <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        acc <= init_val;
        op <= operand;
        remaining <= iter_cnt;
        iters_done <= '0;
        borrow_flag <= 1'b0;
      end else if (state == RUN) begin
        acc <= diff;
        iters_done <= iters_done + CNT_W'(1);
        remaining <= remaining - CNT_W'(1);
        borrow_flag <= step_borrow;
      end
    end
  end
  assign start_ready = state == IDLE;
  assign busy = state == RUN;
  assign res_valid = state == DONE;
  assign result = acc;
endmodule

// File: tb/tb_sub_accum_sequencer.sv
// tb_sub_accum_sequencer: scoreboard bench with a behavioural model of the subtract loop
module tb_sub_accum_sequencer;
  logic clk = 0, rst = 1;
  logic start_valid = 0, res_ready = 1;
  logic start_ready, res_valid, borrow_flag, busy;
  logic [7:0] init_val = 0, result;
  logic [3:0] operand = 0, iter_cnt = 0, iters_done;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    int res;
    int brw;
    int its;
    int cyc;
  } exp_t;
  exp_t sb[$];
  sub_accum_sequencer dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .init_val(init_val), .operand(operand), .iter_cnt(iter_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .borrow_flag(borrow_flag), .iters_done(iters_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t model(input int iv, input int op, input int n, input int k);
    exp_t e;
    int a = iv, it = 0, b = 0;
    for (int i = 0; i < n; i++) begin
      it++;
      if (a < op) begin
        a = (a - op + 256) % 256;
        b = 1;
        break;
      end
      a = a - op;
    end
    e.res = a;
    e.brw = b;
    e.its = it;
    e.cyc = k + it + 1;
    return e;
  endfunction
  task automatic issue(input int iv, input int op, input int n);
    int b = 0;
    init_val = 8'(iv);
    operand = 4'(op);
    iter_cnt = 4'(n);
    start_valid = 1;
    while (!start_ready && b < 200) begin
      step();
      b++;
    end
    chk("accept_ready", int'(start_ready), 1);
    sb.push_back(model(iv, op, n, cyc));
    step();
    start_valid = 0;
    init_val = 8'($urandom);
    operand = 4'($urandom);
    iter_cnt = 4'($urandom);
  endtask
  task automatic wait_idle(input bit rand_ready);
    int b = 0;
    while (!start_ready && b < 200) begin
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
      step();
      b++;
    end
    res_ready = 1;
    chk("idle_timeout", int'(start_ready), 1);
  endtask
  // Monitor: compares each new result, then holds it stable until acknowledged
  bit in_done = 0, prev_hs = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      in_done = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) begin
        chk("idle_after_ack_valid", int'(res_valid), 0);
        chk("idle_after_ack_ready", int'(start_ready), 1);
      end
      if (res_valid) begin
        if (!in_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
            cur = '{res: int'(result), brw: int'(borrow_flag), its: int'(iters_done), cyc: cyc};
          end else begin
            cur = sb.pop_front();
            chk("result", int'(result), cur.res);
            chk("borrow", int'(borrow_flag), cur.brw);
            chk("iters", int'(iters_done), cur.its);
            chk("latency_cycle", cyc, cur.cyc);
          end
          in_done = 1;
        end else begin
          chk("hold_result", int'(result), cur.res);
          chk("hold_borrow", int'(borrow_flag), cur.brw);
          chk("hold_iters", int'(iters_done), cur.its);
        end
        chk("done_start_ready", int'(start_ready), 0);
        chk("done_busy", int'(busy), 0);
      end else in_done = 0;
      prev_hs = res_valid && res_ready;
    end
  end
  initial begin
    step();
    step();
    rst = 0;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_iters", int'(iters_done), 0);
    chk("rst_borrow", int'(borrow_flag), 0);
    issue(100, 5, 3);
    wait_idle(0);
    issue(10, 5, 4);
    wait_idle(0);
    issue(42, 7, 0);
    wait_idle(0);
    issue(200, 0, 15);
    step();
    step();
    start_valid = 1;
    init_val = 8'd1;
    operand = 4'd1;
    iter_cnt = 4'd1;
    chk("run_start_ready", int'(start_ready), 0);
    chk("run_busy", int'(busy), 1);
    step();
    start_valid = 0;
    wait_idle(0);
    res_ready = 0;
    issue(50, 3, 4);
    for (int i = 0; i < 20 && !res_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      start_valid = 1;
      init_val = 8'($urandom);
      step();
    end
    start_valid = 0;
    chk("stall_valid", int'(res_valid), 1);
    res_ready = 1;
    wait_idle(0);
    issue(100, 5, 6);
    step();
    rst = 1;
    sb.delete();
    step();
    rst = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_start_ready", int'(start_ready), 1);
    issue(20, 2, 2);
    wait_idle(0);
    for (int j = 0; j < 30; j++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      wait_idle(1);
    end
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
